// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Purpose  : Register file with an integrated pending-write scoreboard for
//             the pipelined TinyRISC core. Two combinational read ports, one
//             writeback port and one destination-allocation port. A per-
//             register pending bit is set on allocation and cleared on
//             writeback so the issue stage can detect RAW/WAW hazards.
//             Register 0 is hardwired to zero and is never pending.
//  Ports    : clk, rst              - clock, asynchronous active-high reset
//             i_rs1_addr/i_rs2_addr - read addresses
//             o_rs1_data/o_rs2_data - read data (combinational)
//             o_rs1_ready/o_rs2_ready - register not pending
//             i_alloc_valid/i_alloc_rd/o_alloc_ready - destination reservation
//             i_wb_valid/i_wb_rd/i_wb_data - writeback
//             o_pending_count       - registered count of pending registers
//  Config   : REGFILE_BYPASS_EN - when defined, a writeback in the current
//             cycle is forwarded to matching read ports (data and ready).
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_rs1_ready,
    output logic            o_rs2_ready,
    input  logic            i_alloc_valid,
    input  logic [AW-1:0]   i_alloc_rd,
    output logic            o_alloc_ready,
    input  logic            i_wb_valid,
    input  logic [AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [AW:0]     o_pending_count
);

    localparam int c_DEPTH = 1 << AW;
    localparam int c_CW    = AW + 1;

    logic [XLEN-1:0]    r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_pending;
    logic [AW:0]        r_pending_count;

    logic               w_wb_en;
    logic               w_alloc_fire;
    logic               w_set;
    logic               w_clear;
    logic [c_DEPTH-1:0] w_pending_nxt;

    // Writes to register 0 are discarded entirely.
    assign w_wb_en = i_wb_valid && (i_wb_rd != '0);

    // A pending destination may be re-reserved in the same cycle its
    // writeback lands; register 0 is always grantable (and a no-op).
    assign o_alloc_ready = (i_alloc_rd == '0) || !r_pending[i_alloc_rd] ||
                           (i_wb_valid && (i_wb_rd == i_alloc_rd));

    assign w_alloc_fire = i_alloc_valid && o_alloc_ready && (i_alloc_rd != '0);

    // Count only real bit transitions: a set of an already-pending bit, or a
    // clear that is immediately re-set by a same-cycle alloc, is net zero.
    assign w_set   = w_alloc_fire && !r_pending[i_alloc_rd];
    assign w_clear = w_wb_en && r_pending[i_wb_rd] &&
                     !(w_alloc_fire && (i_alloc_rd == i_wb_rd));

    // Alloc is applied after the clear so the newest reservation wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wb_en) begin
            w_pending_nxt[i_wb_rd] = 1'b0;
        end
        if (w_alloc_fire) begin
            w_pending_nxt[i_alloc_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_pending       <= '0;
            r_pending_count <= '0;
        end else begin
            if (w_wb_en) begin
                r_regs[i_wb_rd] <= i_wb_data;
            end
            r_pending       <= w_pending_nxt;
            r_pending_count <= r_pending_count + c_CW'(w_set) - c_CW'(w_clear);
        end
    end

    assign o_pending_count = r_pending_count;

    // Read port 1
    always_comb begin
        o_rs1_data  = r_regs[i_rs1_addr];
        o_rs1_ready = !r_pending[i_rs1_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wb_en && (i_wb_rd == i_rs1_addr)) begin
            o_rs1_data  = i_wb_data;
            o_rs1_ready = 1'b1;
        end
`endif
        if (i_rs1_addr == '0) begin
            o_rs1_data  = '0;
            o_rs1_ready = 1'b1;
        end
    end

    // Read port 2
    always_comb begin
        o_rs2_data  = r_regs[i_rs2_addr];
        o_rs2_ready = !r_pending[i_rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wb_en && (i_wb_rd == i_rs2_addr)) begin
            o_rs2_data  = i_wb_data;
            o_rs2_ready = 1'b1;
        end
`endif
        if (i_rs2_addr == '0) begin
            o_rs2_data  = '0;
            o_rs2_ready = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_scoreboard
//  Purpose  : Self-checking bench for regfile_scoreboard. Expected values are
//             queued when a stimulus step is driven and popped in order when
//             the corresponding DUT outputs are sampled.
//  Config   : REGFILE_BYPASS_EN selects same-cycle forwarding expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   rs1_addr = '0;
    logic [AW-1:0]   rs2_addr = '0;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_ready;
    logic            rs2_ready;
    logic            alloc_valid = 1'b0;
    logic [AW-1:0]   alloc_rd = '0;
    logic            alloc_ready;
    logic            wb_valid = 1'b0;
    logic [AW-1:0]   wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic [AW:0]     pending_count;

    regfile_scoreboard #(.XLEN(XLEN), .AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rs1_addr      (rs1_addr),
        .i_rs2_addr      (rs2_addr),
        .o_rs1_data      (rs1_data),
        .o_rs2_data      (rs2_data),
        .o_rs1_ready     (rs1_ready),
        .o_rs2_ready     (rs2_ready),
        .i_alloc_valid   (alloc_valid),
        .i_alloc_rd      (alloc_rd),
        .o_alloc_ready   (alloc_ready),
        .i_wb_valid      (wb_valid),
        .i_wb_rd         (wb_rd),
        .i_wb_data       (wb_data),
        .o_pending_count (pending_count)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    string       q_tag[$];
    logic [31:0] q_val[$];

    task automatic push_exp(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_val.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        string       tag;
        logic [31:0] e;
        n_cmp++;
        if (q_val.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required a queued expectation", obs);
        end else begin
            tag = q_tag.pop_front();
            e   = q_val.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic exp_rd1(input string tag, input logic [31:0] d, input logic r);
        push_exp({tag, "_rs1_data"}, d);
        push_exp({tag, "_rs1_ready"}, 32'(r));
    endtask

    task automatic exp_rd2(input string tag, input logic [31:0] d, input logic r);
        push_exp({tag, "_rs2_data"}, d);
        push_exp({tag, "_rs2_ready"}, 32'(r));
    endtask

    task automatic obs_rd1();
        observe(rs1_data);
        observe(32'(rs1_ready));
    endtask

    task automatic obs_rd2();
        observe(rs2_data);
        observe(32'(rs2_ready));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held high from time zero
        #2;
        exp_rd1("rst", 32'h0, 1'b1);
        exp_rd2("rst", 32'h0, 1'b1);
        push_exp("rst_count", 32'd0);
        push_exp("rst_alloc_ready", 32'd1);
        obs_rd1(); obs_rd2();
        observe(32'(pending_count));
        observe(32'(alloc_ready));

        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = AW'(a);
            rs2_addr = AW'(31 - a);
            exp_rd1("post_rst_sweep", 32'h0, 1'b1);
            exp_rd2("post_rst_sweep", 32'h0, 1'b1);
            #1;
            obs_rd1(); obs_rd2();
        end
        push_exp("post_rst_count", 32'd0);
        push_exp("post_rst_alloc_ready", 32'd1);
        observe(32'(pending_count));
        observe(32'(alloc_ready));

        // Allocate r5, then RAW hazard, then writeback
        alloc_valid = 1'b1; alloc_rd = 5;
        push_exp("alloc5_ready", 32'd1);
        #1;
        observe(32'(alloc_ready));
        tick();
        alloc_valid = 1'b0; rs1_addr = 5;
        exp_rd1("r5_pending", 32'h0, 1'b0);
        push_exp("r5_count", 32'd1);
        push_exp("r5_realloc_ready", 32'd0);
        #1;
        obs_rd1();
        observe(32'(pending_count));
        observe(32'(alloc_ready));

        wb_valid = 1'b1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        push_exp("r5_wb_alloc_ready", 32'd1);
`ifdef REGFILE_BYPASS_EN
        exp_rd1("r5_wb_same", 32'hDEADBEEF, 1'b1);
`else
        exp_rd1("r5_wb_same", 32'h0, 1'b0);
`endif
        #1;
        observe(32'(alloc_ready));
        obs_rd1();
        tick();
        wb_valid = 1'b0;
        exp_rd1("r5_wb_after", 32'hDEADBEEF, 1'b1);
        push_exp("r5_wb_count", 32'd0);
        #1;
        obs_rd1();
        observe(32'(pending_count));

        // Writeback to a non-pending register, read on port 2 same cycle
        rs2_addr = 7; wb_valid = 1'b1; wb_rd = 7; wb_data = 32'h1234;
`ifdef REGFILE_BYPASS_EN
        exp_rd2("r7_wb_same", 32'h1234, 1'b1);
`else
        exp_rd2("r7_wb_same", 32'h0, 1'b1);
`endif
        #1;
        obs_rd2();
        tick();
        wb_valid = 1'b0;
        exp_rd2("r7_wb_after", 32'h1234, 1'b1);
        push_exp("r7_count", 32'd0);
        #1;
        obs_rd2();
        observe(32'(pending_count));

        // r3 pending; same-cycle writeback and re-allocation of r3
        alloc_valid = 1'b1; alloc_rd = 3;
        tick();
        alloc_valid = 1'b0; rs1_addr = 3;
        exp_rd1("r3_pending", 32'h0, 1'b0);
        push_exp("r3_count", 32'd1);
        #1;
        obs_rd1();
        observe(32'(pending_count));
        wb_valid = 1'b1; wb_rd = 3; wb_data = 32'hA5A5;
        alloc_valid = 1'b1; alloc_rd = 3;
        push_exp("r3_wb_alloc_ready", 32'd1);
        #1;
        observe(32'(alloc_ready));
        tick();
        wb_valid = 1'b0; alloc_valid = 1'b0;
        exp_rd1("r3_wb_alloc_after", 32'hA5A5, 1'b0);
        push_exp("r3_wb_alloc_count", 32'd1);
        #1;
        obs_rd1();
        observe(32'(pending_count));

        // Alloc r9 while r3 writes back: net count change zero
        alloc_valid = 1'b1; alloc_rd = 9;
        wb_valid = 1'b1; wb_rd = 3; wb_data = 32'h77;
        tick();
        alloc_valid = 1'b0; wb_valid = 1'b0; rs1_addr = 3; rs2_addr = 9;
        exp_rd1("swap_r3", 32'h77, 1'b1);
        exp_rd2("swap_r9", 32'h0, 1'b0);
        push_exp("swap_count", 32'd1);
        #1;
        obs_rd1(); obs_rd2();
        observe(32'(pending_count));

        // Register 0: alloc and writeback both ignored
        alloc_valid = 1'b1; alloc_rd = 0;
        wb_valid = 1'b1; wb_rd = 0; wb_data = 32'hFFFFFFFF; rs1_addr = 0;
        push_exp("r0_alloc_ready", 32'd1);
        exp_rd1("r0_same", 32'h0, 1'b1);
        #1;
        observe(32'(alloc_ready));
        obs_rd1();
        tick();
        alloc_valid = 1'b0; wb_valid = 1'b0;
        exp_rd1("r0_after", 32'h0, 1'b1);
        push_exp("r0_count", 32'd1);
        #1;
        obs_rd1();
        observe(32'(pending_count));

        // Drain r9, then allocate every register 1..31
        wb_valid = 1'b1; wb_rd = 9; wb_data = 32'h99;
        tick();
        wb_valid = 1'b0;
        push_exp("drain_count", 32'd0);
        #1;
        observe(32'(pending_count));
        for (int r = 1; r < 32; r++) begin
            alloc_valid = 1'b1; alloc_rd = AW'(r);
            tick();
        end
        alloc_valid = 1'b0; alloc_rd = 17; rs1_addr = 5;
        push_exp("full_count", 32'd31);
        push_exp("full_alloc_ready", 32'd0);
        exp_rd1("full_r5", 32'hDEADBEEF, 1'b0);
        #1;
        observe(32'(pending_count));
        observe(32'(alloc_ready));
        obs_rd1();

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_rd1("async_rst", 32'h0, 1'b1);
        push_exp("async_rst_count", 32'd0);
        push_exp("async_rst_alloc_ready", 32'd1);
        #1;
        obs_rd1();
        observe(32'(pending_count));
        observe(32'(alloc_ready));

        // In-flight writeback after release lands on a non-pending register
        @(negedge clk);
        rst = 1'b0;
        wb_valid = 1'b1; wb_rd = 5; wb_data = 32'h55;
        tick();
        wb_valid = 1'b0;
        exp_rd1("post_rst_wb", 32'h55, 1'b1);
        push_exp("post_rst_wb_count", 32'd0);
        #1;
        obs_rd1();
        observe(32'(pending_count));

        n_cmp++;
        assert (q_val.size() === 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", q_val.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
